velocity_cell_update_ctrl: RTL and testbench

//  Motion-update sequencer for one cell's velocity RAM (single-port, 1-cycle read, addr 0 = particle count).
//  On start: reads count, streams velocities of particles 1..N to the motion-update unit (valid/ready).

---
 rtl/md_cell_pkg.sv | 20 ++
 rtl/vel_skid_fifo.sv | 45 ++++
 rtl/velocity_cell_update_ctrl.sv | 149 ++++++++++++++
 tb/tb_velocity_cell_update_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_cell_pkg.sv
// Shared definitions for the cell motion-update datapath: velocity word layout and
// the update sequencer's state encoding.
package md_cell_pkg;

  localparam int VEL_WIDTH  = 96;
  localparam int COMP_WIDTH = 32;
  localparam int VX_LSB     = 0;
  localparam int VY_LSB     = 32;
  localparam int VZ_LSB     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vel_skid_fifo.sv
// Two-entry FIFO holding returned velocity words with their particle id.
// Head is visible combinationally; the caller guarantees no push when full without a pop.
module vel_skid_fifo #(
  parameter int WIDTH = 104
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] entry [2];
  logic             rd_idx;
  logic             wr_idx;
  logic             do_pop;

  assign do_pop = pop && (occ != 2'd0);
  assign head   = entry[rd_idx];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      rd_idx   <= 1'b0;
      wr_idx   <= 1'b0;
      occ      <= 2'd0;
    end else if (flush) begin
      rd_idx <= 1'b0;
      wr_idx <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_idx] <= push_data;
        wr_idx        <= ~wr_idx;
      end
      if (do_pop) rd_idx <= ~rd_idx;
      occ <= occ + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/velocity_cell_update_ctrl.sv
// Motion-update sequencer for one cell's velocity RAM: reads the particle count, streams
// velocities 1..N out over valid/ready and writes the in-order updates back to 1..N.
module velocity_cell_update_ctrl
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = VEL_WIDTH,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_cnt,
  output logic                  cnt_err,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] vel_out,
  output logic [ADDR_WIDTH-1:0] vel_out_id,
  output logic                  vel_out_valid,
  input  logic                  vel_out_ready,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_valid
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH;

  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, wb_ptr, q_cnt, cnt_clamped;
  logic [3:0] wait_cnt, inflight, credit_used;
  logic [RD_LATENCY-1:0] sh_vld;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] sh_id;
  logic [RD_LATENCY:0] sh_vld_nxt;
  logic [RD_LATENCY:0][ADDR_WIDTH-1:0] sh_id_nxt;
  logic [FW-1:0] fifo_head;
  logic [1:0] fifo_occ;
  logic cnt_over, start_acc, wait_last, wb_pending, wb_write, rd_issue, fifo_pop, fifo_push;

  assign q_cnt       = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over    = q_cnt > MAX_CNT;
  assign cnt_clamped = cnt_over ? MAX_CNT : q_cnt;
  assign wait_last   = (wait_cnt == 4'(RD_LATENCY - 1));
  assign start_acc   = (state == ST_IDLE) && start;
  assign wb_pending  = ((state == ST_STREAM) || (state == ST_DRAIN)) && (wb_ptr <= particle_cnt);
  assign wb_write    = wb_valid && wb_pending;

  // Reads are credited against FIFO space, counting the entry leaving this cycle, so the
  // two FIFO slots can never be oversubscribed by data still in the RAM pipeline.
  assign vel_out_valid = (fifo_occ != 2'd0);
  assign fifo_pop      = vel_out_valid && vel_out_ready;
  assign inflight      = 4'($countones(sh_vld));
  assign credit_used   = {2'b00, fifo_occ} + inflight - {3'b000, fifo_pop};
  assign rd_issue      = (state == ST_STREAM) && (rd_ptr <= particle_cnt)
                         && (credit_used < 4'd2) && !wb_write;
  assign fifo_push     = sh_vld[RD_LATENCY-1];
  assign sh_vld_nxt    = {sh_vld, rd_issue};
  assign sh_id_nxt     = {sh_id, rd_ptr};

  assign vel_out    = vel_out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign vel_out_id = vel_out_valid ? fifo_head[FW-1:DATA_WIDTH] : '0;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);

  vel_skid_fifo #(.WIDTH(FW)) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .flush     (start_acc),
    .push      (fifo_push),
    .push_data ({sh_id[RD_LATENCY-1], mem_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .occ       (fifo_occ)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_RD_CNT;
      ST_RD_CNT:   state_nxt = ST_WAIT_CNT;
      ST_WAIT_CNT: if (wait_last) state_nxt = (cnt_clamped == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM:   if (rd_issue && (rd_ptr == particle_cnt)) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (!wb_pending || (wb_write && (wb_ptr == particle_cnt))) state_nxt = ST_DONE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Write-back owns the port when present; a blocked read simply retries next cycle.
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (wb_write) begin
      mem_wren    = 1'b1;
      mem_address = wb_ptr;
      mem_data    = wb_data;
    end else if (state == ST_RD_CNT) begin
      mem_rden = 1'b1;
    end else if (rd_issue) begin
      mem_rden    = 1'b1;
      mem_address = rd_ptr;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      particle_cnt <= '0;
      cnt_err      <= 1'b0;
      wb_err       <= 1'b0;
      rd_ptr       <= '0;
      wb_ptr       <= '0;
      wait_cnt     <= 4'd0;
      sh_vld       <= '0;
      sh_id        <= '0;
    end else begin
      if (start_acc) begin
        particle_cnt <= '0;
        cnt_err      <= 1'b0;
        wb_err       <= 1'b0;
        rd_ptr       <= ADDR_WIDTH'(1);
        wb_ptr       <= ADDR_WIDTH'(1);
      end else begin
        if ((state == ST_WAIT_CNT) && wait_last) begin
          particle_cnt <= cnt_clamped;
          cnt_err      <= cnt_over;
        end
        if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        if (wb_write) wb_ptr <= wb_ptr + ADDR_WIDTH'(1);
        if (wb_valid && !wb_pending) wb_err <= 1'b1;
      end
      wait_cnt <= (state == ST_WAIT_CNT) ? wait_cnt + 4'd1 : 4'd0;
      sh_vld   <= sh_vld_nxt[RD_LATENCY-1:0];
      sh_id    <= sh_id_nxt[RD_LATENCY-1:0];
    end
  end

endmodule

// File: tb/tb_velocity_cell_update_ctrl.sv
// Directed bench for velocity_cell_update_ctrl: RAM model, consumer with delayed write-back,
// per-scenario tasks with hand-derived expectations.
module tb_velocity_cell_update_ctrl;
  import md_cell_pkg::*;

  logic clock = 1'b0, rst_n = 1'b0, start = 1'b0, vel_out_ready = 1'b0;
  logic [7:0] cnt_val = 8'd0;
  logic ram_clr = 1'b0, auto_wb = 1'b0, auto_v = 1'b0, man_v = 1'b0;
  logic [95:0] auto_d = '0, man_d = '0, mem_q = '0;
  logic busy, done, cnt_err, wb_err, mem_rden, mem_wren, vel_out_valid, wb_valid;
  logic [7:0] particle_cnt, mem_address, vel_out_id;
  logic [95:0] mem_data, vel_out, wb_data;
  logic [95:0] ram [0:219];
  logic wflag [0:219];

  localparam logic [95:0] XK = {3{32'h00FF_00FF}};

  int cyc = 0, vectors = 0, miscompares = 0, done_cnt = 0, both_cnt = 0, outst = 0;
  int rd_log[$], wr_a[$], id_log[$], wbq_due[$];
  logic [95:0] wr_d[$], vo_log[$], wbq_dat[$];

  assign wb_valid = auto_v | man_v;
  assign wb_data  = auto_v ? auto_d : man_d;

  velocity_cell_update_ctrl dut (
    .clock(clock), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .particle_cnt(particle_cnt), .cnt_err(cnt_err), .wb_err(wb_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_q(mem_q), .vel_out(vel_out), .vel_out_id(vel_out_id), .vel_out_valid(vel_out_valid),
    .vel_out_ready(vel_out_ready), .wb_data(wb_data), .wb_valid(wb_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [95:0] pat(input int a);
    logic [95:0] v;
    v = '0;
    v[VX_LSB +: COMP_WIDTH] = 32'h1000_0000 + 32'(a);
    v[VY_LSB +: COMP_WIDTH] = 32'h2000_0000 + 32'(a);
    v[VZ_LSB +: COMP_WIDTH] = 32'h3000_0000 + 32'(a);
    return v;
  endfunction

  // Single-port RAM: address 0 returns the count, untouched words return the preload pattern.
  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 220; i++) wflag[i] <= 1'b0;
    end else if (mem_wren) begin
      ram[mem_address]   <= mem_data;
      wflag[mem_address] <= 1'b1;
    end
    if (mem_rden)
      mem_q <= (mem_address == 8'd0) ? {88'd0, cnt_val}
             : (wflag[mem_address] ? ram[mem_address] : pat(int'(mem_address)));
  end

  // Consumer/monitor: logs bus activity at negedge, drives delayed write-backs after posedge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (!rst_n || !auto_wb) begin wbq_due.delete(); wbq_dat.delete(); end
      if (wbq_due.size() > 0 && wbq_due[0] <= cyc) begin
        auto_v = 1'b1; auto_d = wbq_dat[0];
        void'(wbq_due.pop_front()); void'(wbq_dat.pop_front());
      end else begin
        auto_v = 1'b0; auto_d = '0;
      end
      @(negedge clock);
      if (mem_rden) rd_log.push_back(int'(mem_address));
      if (mem_rden && mem_wren) both_cnt++;
      if (mem_wren) begin wr_a.push_back(int'(mem_address)); wr_d.push_back(mem_data); end
      if (done) done_cnt++;
      if (!rst_n) outst = 0;
      else begin
        if (mem_rden && mem_address != 8'd0) outst++;
        if (vel_out_valid && vel_out_ready) begin
          id_log.push_back(int'(vel_out_id)); vo_log.push_back(vel_out); outst--;
          if (auto_wb) begin wbq_due.push_back(cyc + 2); wbq_dat.push_back(vel_out ^ XK); end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic clear_ram();
    ram_clr = 1'b1; tick(); ram_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (!done && n < budget) begin tick(); n++; end
    vectors++;
    if (done !== 1'b1) begin
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", nm, done, n);
      miscompares++;
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    ram_clr = 1'b1;
    tick(); tick();
    vectors++;
    if ({busy, done, particle_cnt, cnt_err, wb_err, mem_address, mem_rden, mem_wren,
         vel_out_id, vel_out_valid} !== '0 || mem_data !== '0 || vel_out !== '0) begin
      $display("FAIL reset_outputs: busy=%b done=%b cnt=%0d rden=%b wren=%b valid=%b, required all 0",
               busy, done, particle_cnt, mem_rden, mem_wren, vel_out_valid);
      miscompares++;
    end
    rst_n = 1'b1; ram_clr = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || mem_rden !== 1'b0) begin
      $display("FAIL reset_idle: busy=%b rden=%b, required 0 0", busy, mem_rden);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    int r0, w0, i0, d0;
    clear_ram();
    cnt_val = 8'd3; vel_out_ready = 1'b1; auto_wb = 1'b1;
    r0 = rd_log.size(); w0 = wr_a.size(); i0 = id_log.size(); d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(200, "basic");
    vectors++;
    if (rd_log.size() - r0 != 4) begin
      $display("FAIL basic_reads: %0d reads, required 4", rd_log.size() - r0); miscompares++;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (rd_log[r0 + k] != k) begin
        $display("FAIL basic_rd_addr[%0d]: %0d, required %0d", k, rd_log[r0 + k], k); miscompares++;
      end
    end
    vectors++;
    if (wr_a.size() - w0 != 3) begin
      $display("FAIL basic_writes: %0d writes, required 3", wr_a.size() - w0); miscompares++;
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (wr_a[w0 + k] != k + 1 || wr_d[w0 + k] !== (pat(k + 1) ^ XK)) begin
        $display("FAIL basic_wr[%0d]: addr %0d data %h, required addr %0d data %h",
                 k, wr_a[w0 + k], wr_d[w0 + k], k + 1, pat(k + 1) ^ XK); miscompares++;
      end
      vectors++;
      if (id_log[i0 + k] != k + 1 || vo_log[i0 + k] !== pat(k + 1)) begin
        $display("FAIL basic_vel[%0d]: id %0d data %h, required id %0d data %h",
                 k, id_log[i0 + k], vo_log[i0 + k], k + 1, pat(k + 1)); miscompares++;
      end
    end
    vectors++;
    if (done_cnt - d0 != 1 || particle_cnt !== 8'd3 || cnt_err !== 1'b0 || wb_err !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_status: dones=%0d cnt=%0d cnt_err=%b wb_err=%b busy=%b, required 1 3 0 0 0",
               done_cnt - d0, particle_cnt, cnt_err, wb_err, busy); miscompares++;
    end
  endtask

  task automatic test_zero();
    int r0, w0, i0;
    clear_ram();
    cnt_val = 8'd0; vel_out_ready = 1'b1; auto_wb = 1'b1;
    r0 = rd_log.size(); w0 = wr_a.size(); i0 = id_log.size();
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (mem_rden !== 1'b1 || mem_address !== 8'd0 || busy !== 1'b1) begin
      $display("FAIL zero_rd_cnt: rden=%b addr=%0d busy=%b, required 1 0 1", mem_rden, mem_address, busy);
      miscompares++;
    end
    tick();
    vectors++;
    if (mem_rden !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL zero_wait: rden=%b busy=%b done=%b, required 0 1 0", mem_rden, busy, done); miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL zero_done: done=%b busy=%b, required 1 0", done, busy); miscompares++;
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_rden !== 1'b0) begin
      $display("FAIL zero_start_in_done: done=%b busy=%b rden=%b, required 0 0 0", done, busy, mem_rden);
      miscompares++;
    end
    tick();
    vectors++;
    if (rd_log.size() - r0 != 1 || wr_a.size() != w0 || id_log.size() != i0 || particle_cnt !== 8'd0) begin
      $display("FAIL zero_traffic: reads=%0d writes=%0d vel=%0d cnt=%0d, required 1 0 0 0",
               rd_log.size() - r0, wr_a.size() - w0, id_log.size() - i0, particle_cnt); miscompares++;
    end
  endtask

  task automatic test_clamp();
    int r0, w0, i0, d0;
    clear_ram();
    cnt_val = 8'd250; vel_out_ready = 1'b1; auto_wb = 1'b1;
    r0 = rd_log.size(); w0 = wr_a.size(); i0 = id_log.size(); d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(3000, "clamp");
    vectors++;
    if (particle_cnt !== 8'd219 || cnt_err !== 1'b1) begin
      $display("FAIL clamp_cnt: cnt=%0d cnt_err=%b, required 219 1", particle_cnt, cnt_err); miscompares++;
    end
    vectors++;
    if (rd_log.size() - r0 != 220 || wr_a.size() - w0 != 219 || id_log.size() - i0 != 219 || done_cnt - d0 != 1) begin
      $display("FAIL clamp_traffic: reads=%0d writes=%0d vel=%0d dones=%0d, required 220 219 219 1",
               rd_log.size() - r0, wr_a.size() - w0, id_log.size() - i0, done_cnt - d0); miscompares++;
    end
    vectors++;
    if (wr_a[wr_a.size() - 1] != 219 || wr_d[wr_d.size() - 1] !== (pat(219) ^ XK)) begin
      $display("FAIL clamp_last_wr: addr %0d data %h, required 219 %h",
               wr_a[wr_a.size() - 1], wr_d[wr_d.size() - 1], pat(219) ^ XK); miscompares++;
    end
  endtask

  task automatic test_stall();
    int r0, w0, i0, maxo, bad;
    clear_ram();
    cnt_val = 8'd5; vel_out_ready = 1'b0; auto_wb = 1'b1;
    r0 = rd_log.size(); w0 = wr_a.size(); i0 = id_log.size();
    maxo = 0; bad = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) begin
      tick();
      if (outst > maxo) maxo = outst;
      if (vel_out_valid && (vel_out_id !== 8'd1 || vel_out !== pat(1))) bad++;
    end
    vectors++;
    if (maxo != 2 || rd_log.size() - r0 != 3 || bad != 0) begin
      $display("FAIL stall_outstanding: max=%0d reads=%0d unstable=%0d, required 2 3 0",
               maxo, rd_log.size() - r0, bad); miscompares++;
    end
    vectors++;
    if (vel_out_valid !== 1'b1 || vel_out_id !== 8'd1 || cnt_err !== 1'b0) begin
      $display("FAIL stall_head: valid=%b id=%0d cnt_err=%b, required 1 1 0", vel_out_valid, vel_out_id, cnt_err);
      miscompares++;
    end
    vel_out_ready = 1'b1;
    wait_done(200, "stall");
    vectors++;
    if (id_log.size() - i0 != 5 || wr_a.size() - w0 != 5) begin
      $display("FAIL stall_counts: vel=%0d writes=%0d, required 5 5", id_log.size() - i0, wr_a.size() - w0);
      miscompares++;
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (id_log[i0 + k] != k + 1 || vo_log[i0 + k] !== pat(k + 1)) begin
        $display("FAIL stall_order[%0d]: id %0d data %h, required id %0d data %h",
                 k, id_log[i0 + k], vo_log[i0 + k], k + 1, pat(k + 1)); miscompares++;
      end
    end
  endtask

  task automatic test_collision();
    int w0, i0;
    clear_ram();
    cnt_val = 8'd4; vel_out_ready = 1'b1; auto_wb = 1'b0;
    w0 = wr_a.size(); i0 = id_log.size();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    vectors++;
    if (mem_rden !== 1'b1 || mem_address !== 8'd1) begin
      $display("FAIL coll_first_read: rden=%b addr=%0d, required 1 1", mem_rden, mem_address); miscompares++;
    end
    tick();
    man_v = 1'b1; man_d = pat(1) ^ XK;
    #1;
    vectors++;
    if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || mem_address !== 8'd1 || mem_data !== (pat(1) ^ XK)) begin
      $display("FAIL coll_write_prio: wren=%b rden=%b addr=%0d data %h, required 1 0 1 %h",
               mem_wren, mem_rden, mem_address, mem_data, pat(1) ^ XK); miscompares++;
    end
    tick();
    man_v = 1'b0; man_d = '0;
    #1;
    vectors++;
    if (mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_address !== 8'd2) begin
      $display("FAIL coll_retry: rden=%b wren=%b addr=%0d, required 1 0 2", mem_rden, mem_wren, mem_address);
      miscompares++;
    end
    tick();
    auto_wb = 1'b1;
    wait_done(200, "coll");
    vectors++;
    if (wr_a.size() - w0 != 4 || id_log.size() - i0 != 4) begin
      $display("FAIL coll_counts: writes=%0d vel=%0d, required 4 4", wr_a.size() - w0, id_log.size() - i0);
      miscompares++;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wr_a[w0 + k] != k + 1 || wr_d[w0 + k] !== (pat(k + 1) ^ XK) || vo_log[i0 + k] !== pat(k + 1)) begin
        $display("FAIL coll_data[%0d]: addr %0d wdata %h vel %h, required addr %0d wdata %h vel %h",
                 k, wr_a[w0 + k], wr_d[w0 + k], vo_log[i0 + k], k + 1, pat(k + 1) ^ XK, pat(k + 1));
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int r0, w0;
    clear_ram();
    cnt_val = 8'd8; vel_out_ready = 1'b1; auto_wb = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, mem_rden, mem_wren, vel_out_valid, mem_address, particle_cnt} !== '0) begin
      $display("FAIL rst_mid_outputs: busy=%b rden=%b wren=%b valid=%b addr=%0d cnt=%0d, required all 0",
               busy, mem_rden, mem_wren, vel_out_valid, mem_address, particle_cnt); miscompares++;
    end
    r0 = rd_log.size(); w0 = wr_a.size();
    tick(); tick();
    vectors++;
    if (rd_log.size() != r0 || wr_a.size() != w0) begin
      $display("FAIL rst_mid_quiet: reads=%0d writes=%0d during reset, required 0 0",
               rd_log.size() - r0, wr_a.size() - w0); miscompares++;
    end
    rst_n = 1'b1; auto_wb = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || wb_err !== 1'b0) begin
      $display("FAIL rst_mid_idle: busy=%b wb_err=%b, required 0 0", busy, wb_err); miscompares++;
    end
    man_v = 1'b1; man_d = pat(7);
    #1;
    vectors++;
    if (mem_wren !== 1'b0) begin
      $display("FAIL rst_mid_wb_ignored: wren=%b, required 0", mem_wren); miscompares++;
    end
    tick();
    man_v = 1'b0; man_d = '0;
    vectors++;
    if (wb_err !== 1'b1 || wr_a.size() != w0 || busy !== 1'b0) begin
      $display("FAIL rst_mid_wb_err: wb_err=%b writes=%0d busy=%b, required 1 0 0",
               wb_err, wr_a.size() - w0, busy); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_stall();
    test_collision();
    test_reset_mid();
    vectors++;
    if (both_cnt != 0) begin
      $display("FAIL rden_wren_exclusive: %0d cycles with both, required 0", both_cnt); miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
